// File: rtl/hazard_scoreboard_unit.sv
// Hazard unit with long-latency scoreboard for a 5-stage RV32 pipeline (forwarding, stalls, flushes).
// Latency: stall/flush/forward outputs are combinational (0 cycles); scoreboard updates are visible one cycle after the edge.
// Backpressure: stallF/stallD hold F and D, flushE inserts a bubble; the long unit is held off by ststall at MAX_OUT in flight.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   rs1D/rs2D/rdD/longopD      decode-stage register fields and long-op flag
//   rs1E/rs2E/rdE/longopE      execute-stage fields; longopE issues to the long unit
//   rdM/rdW/regwriteM/W        memory/writeback destinations and write enables
//   resultsrcEb0, pcsrcE       E is a load, E branch/jump taken
//   long_done, long_rd         long unit writeback this cycle and its destination
//   forwardaE/bE               00 RF, 01 W result, 10 M result
//   stallF/stallD/flushD/flushE pipeline control
//   pend_cnt                   long ops in flight
//   perf_stall/perf_flush      saturating event counters
// Optional build macro HAZ_PERF_CNT_EN: enables the perf counters; otherwise they read 0.

module hazard_scoreboard_unit #(
  parameter int AW      = 5,
  parameter int MAX_OUT = 2,
  parameter int CW      = 16,
  localparam int NREG   = 2 ** AW,
  localparam int CNTW   = $clog2(MAX_OUT + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   rs1D,
  input  logic [AW-1:0]   rs2D,
  input  logic [AW-1:0]   rdD,
  input  logic            longopD,
  input  logic [AW-1:0]   rs1E,
  input  logic [AW-1:0]   rs2E,
  input  logic [AW-1:0]   rdE,
  input  logic            longopE,
  input  logic [AW-1:0]   rdM,
  input  logic [AW-1:0]   rdW,
  input  logic            regwriteM,
  input  logic            regwriteW,
  input  logic            resultsrcEb0,
  input  logic            pcsrcE,
  input  logic            long_done,
  input  logic [AW-1:0]   long_rd,
  output logic [1:0]      forwardaE,
  output logic [1:0]      forwardbE,
  output logic            stallF,
  output logic            stallD,
  output logic            flushD,
  output logic            flushE,
  output logic [CNTW-1:0] pend_cnt,
  output logic [CW-1:0]   perf_stall,
  output logic [CW-1:0]   perf_flush
);

  logic [NREG-1:1] pending;
  logic [NREG-1:1] pendingNext;
  logic [NREG-1:0] pendFull;
  logic [CNTW-1:0] pendCnt;
  logic            doneOk;
  logic            lwStall;
  logic            sbStall;
  logic            stStall;
  logic            stall;

  // M result is younger than W, so it wins when both match.
  function automatic logic [1:0] fwdSel(input logic [AW-1:0] rs);
    logic [1:0] sel;
    sel = 2'b00;
    if (rs != '0) begin
      if (regwriteM && (rs == rdM))      sel = 2'b10;
      else if (regwriteW && (rs == rdW)) sel = 2'b01;
    end
    return sel;
  endfunction

  assign forwardaE = fwdSel(rs1E);
  assign forwardbE = fwdSel(rs2E);

  // Bit 0 is a constant zero so x0 lookups never hit.
  assign pendFull = {pending, 1'b0};

  // A completion with nothing in flight is spurious and is dropped entirely.
  assign doneOk = long_done && (pendCnt != '0);

  // Clear-then-set: a same-register complete and issue leaves the bit set.
  always_comb begin
    pendingNext = pending;
    for (int i = 1; i < NREG; i++) begin
      pendingNext[i] = (pending[i] && !(doneOk && (long_rd == AW'(i))))
                     || (longopE && (rdE == AW'(i)));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      pendCnt <= '0;
    end else begin
      pending <= pendingNext;
      // An issue to x0 still occupies a slot in the long unit.
      if (longopE && !doneOk)      pendCnt <= pendCnt + CNTW'(1);
      else if (doneOk && !longopE) pendCnt <= pendCnt - CNTW'(1);
    end
  end

  assign pend_cnt = pendCnt;

  assign lwStall = resultsrcEb0 && (rdE != '0) && ((rs1D == rdE) || (rs2D == rdE));
  // rdD lookup catches WAW against an older long op still in flight.
  assign sbStall = pendFull[rs1D] | pendFull[rs2D] | pendFull[rdD];
  // A completion this cycle frees a slot, so the new long op may proceed.
  assign stStall = longopD && (pendCnt == CNTW'(MAX_OUT)) && !long_done;
  assign stall   = lwStall | sbStall | stStall;

  assign stallF = stall;
  assign stallD = stall;
  // With a taken branch and a stall together, flushD clears IF-ID regardless of stallD.
  assign flushD = pcsrcE;
  assign flushE = pcsrcE | stall;

`ifdef HAZ_PERF_CNT_EN
  logic [CW-1:0] perfStallQ;
  logic [CW-1:0] perfFlushQ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perfStallQ <= '0;
      perfFlushQ <= '0;
    end else begin
      if (stall && (perfStallQ != {CW{1'b1}}))  perfStallQ <= perfStallQ + CW'(1);
      if (pcsrcE && (perfFlushQ != {CW{1'b1}})) perfFlushQ <= perfFlushQ + CW'(1);
    end
  end

  assign perf_stall = perfStallQ;
  assign perf_flush = perfFlushQ;
`else
  assign perf_stall = '0;
  assign perf_flush = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
module tb_hazard_scoreboard_unit;

  logic       clk;
  logic       rst_n;
  logic [4:0] rs1D, rs2D, rdD, rs1E, rs2E, rdE, rdM, rdW, long_rd;
  logic       longopD, longopE, regwriteM, regwriteW, resultsrcEb0, pcsrcE, long_done;
  logic [1:0] forwardaE, forwardbE;
  logic       stallF, stallD, flushD, flushE;
  logic [1:0] pend_cnt;
  logic [3:0] perf_stall, perf_flush;

  int checks;
  int failures;

  hazard_scoreboard_unit #(.AW(5), .MAX_OUT(2), .CW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1D(rs1D), .rs2D(rs2D), .rdD(rdD), .longopD(longopD),
    .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE), .longopE(longopE),
    .rdM(rdM), .rdW(rdW), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .resultsrcEb0(resultsrcEb0), .pcsrcE(pcsrcE),
    .long_done(long_done), .long_rd(long_rd),
    .forwardaE(forwardaE), .forwardbE(forwardbE),
    .stallF(stallF), .stallD(stallD), .flushD(flushD), .flushE(flushE),
    .pend_cnt(pend_cnt), .perf_stall(perf_stall), .perf_flush(perf_flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs1D, rs2D, rdD;
    logic       longopD;
    logic [4:0] rs1E, rs2E, rdE, rdM, rdW;
    logic       regwriteM, regwriteW, resultsrcEb0, pcsrcE;
    logic [1:0] expFa, expFb;
    logic       expStall, expFlushD, expFlushE;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clearInputs();
    rs1D = '0; rs2D = '0; rdD = '0; rs1E = '0; rs2E = '0; rdE = '0;
    rdM = '0; rdW = '0; long_rd = '0;
    longopD = 1'b0; longopE = 1'b0; regwriteM = 1'b0; regwriteW = 1'b0;
    resultsrcEb0 = 1'b0; pcsrcE = 1'b0; long_done = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    //          rs1D   rs2D   rdD  lD   rs1E   rs2E   rdE    rdM    rdW   rwM  rwW  ld   pc    fa     fb    st   fD   fE
    vecs[0]  = '{5'd0, 5'd0, 5'd0, 1'b0, 5'd5, 5'd0, 5'd0, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 2'd0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{5'd0, 5'd0, 5'd0, 1'b0, 5'd5, 5'd0, 5'd0, 5'd5, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 2'd0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{5'd0, 5'd0, 5'd0, 1'b0, 5'd3, 5'd6, 5'd0, 5'd6, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 2'd2, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{5'd0, 5'd7, 5'd0, 1'b0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b1};
    vecs[5]  = '{5'd0, 5'd7, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{5'd7, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{5'd7, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0, 1'b1, 1'b1};
    vecs[9]  = '{5'd0, 5'd7, 5'd0, 1'b0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 1'b1, 1'b1, 1'b1};
    vecs[10] = '{5'd0, 5'd0, 5'd0, 1'b1, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd9, 5'd0, 5'd9, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd1, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0;
    clearInputs();
    repeat (2) @(negedge clk);
    #1;
    chk("reset_pend_cnt", int'(pend_cnt), 0);
    chk("reset_stallF", int'(stallF), 0);
    chk("reset_flushE", int'(flushE), 0);
    chk("reset_perf_stall", int'(perf_stall), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Combinational table: state stays empty (no long issue/complete).
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      clearInputs();
      rs1D = vecs[i].rs1D; rs2D = vecs[i].rs2D; rdD = vecs[i].rdD; longopD = vecs[i].longopD;
      rs1E = vecs[i].rs1E; rs2E = vecs[i].rs2E; rdE = vecs[i].rdE;
      rdM = vecs[i].rdM; rdW = vecs[i].rdW;
      regwriteM = vecs[i].regwriteM; regwriteW = vecs[i].regwriteW;
      resultsrcEb0 = vecs[i].resultsrcEb0; pcsrcE = vecs[i].pcsrcE;
      #1;
      chk($sformatf("vec%0d_forwardaE", i), int'(forwardaE), int'(vecs[i].expFa));
      chk($sformatf("vec%0d_forwardbE", i), int'(forwardbE), int'(vecs[i].expFb));
      chk($sformatf("vec%0d_stallF", i), int'(stallF), int'(vecs[i].expStall));
      chk($sformatf("vec%0d_stallD", i), int'(stallD), int'(vecs[i].expStall));
      chk($sformatf("vec%0d_flushD", i), int'(flushD), int'(vecs[i].expFlushD));
      chk($sformatf("vec%0d_flushE", i), int'(flushE), int'(vecs[i].expFlushE));
    end

    // Scoreboard RAW on rd 9.
    @(negedge clk); clearInputs(); longopE = 1'b1; rdE = 5'd9; #1;
    chk("raw_cnt_before", int'(pend_cnt), 0);
    @(negedge clk); clearInputs(); rs1D = 5'd9; #1;
    chk("raw_stall_n1", int'(stallD), 1);
    chk("raw_cnt_n1", int'(pend_cnt), 1);
    chk("raw_flushE_n1", int'(flushE), 1);
    chk("raw_flushD_n1", int'(flushD), 0);
    @(negedge clk); #1;
    chk("raw_stall_n2", int'(stallD), 1);
    @(negedge clk); long_done = 1'b1; long_rd = 5'd9; #1;
    chk("raw_stall_done_cycle", int'(stallD), 1);
    @(negedge clk); long_done = 1'b0; long_rd = '0; #1;
    chk("raw_stall_after", int'(stallD), 0);
    chk("raw_cnt_after", int'(pend_cnt), 0);
    // Spurious completion with nothing in flight.
    rs1D = '0; long_done = 1'b1; long_rd = 5'd9;
    @(negedge clk); long_done = 1'b0; long_rd = '0; #1;
    chk("underflow_cnt", int'(pend_cnt), 0);

    // Structural limit with MAX_OUT=2.
    @(negedge clk); clearInputs(); longopE = 1'b1; rdE = 5'd3;
    @(negedge clk); rdE = 5'd4; #1;
    chk("st_cnt1", int'(pend_cnt), 1);
    @(negedge clk); clearInputs(); longopD = 1'b1; #1;
    chk("st_cnt2", int'(pend_cnt), 2);
    chk("st_stall", int'(stallF), 1);
    long_done = 1'b1; long_rd = 5'd3; #1;
    chk("st_stall_done", int'(stallF), 0);
    longopE = 1'b1; rdE = 5'd5; #1;
    chk("st_stall_done_issue", int'(stallF), 0);
    @(negedge clk); clearInputs(); #1;
    chk("st_cnt_same_cycle", int'(pend_cnt), 2);
    rs1D = 5'd3; #1;
    chk("sb_rd3_cleared", int'(stallD), 0);
    rs1D = 5'd5; #1;
    chk("sb_rd5_set", int'(stallD), 1);
    rs1D = '0; rdD = 5'd4; #1;
    chk("sb_waw_rd4", int'(stallD), 1);
    rdD = '0; long_done = 1'b1; long_rd = 5'd5; longopE = 1'b1; rdE = 5'd5;
    @(negedge clk); clearInputs(); rs2D = 5'd5; #1;
    chk("same_reg_bit_set", int'(stallD), 1);
    chk("same_reg_cnt", int'(pend_cnt), 2);

    // Taken branch with load-use, then reset mid-stall.
    clearInputs(); resultsrcEb0 = 1'b1; rdE = 5'd7; rs1D = 5'd7; pcsrcE = 1'b1; #1;
    chk("br_ld_flushD", int'(flushD), 1);
    chk("br_ld_flushE", int'(flushE), 1);
    chk("br_ld_stallD", int'(stallD), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_cnt", int'(pend_cnt), 0);
    clearInputs(); rs1D = 5'd5; rdD = 5'd4; #1;
    chk("arst_pending_clear", int'(stallD), 0);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("post_rst_stall", int'(stallD), 0);
    chk("post_rst_cnt", int'(pend_cnt), 0);

    // Perf counters: 20 stall cycles, 3 flush cycles.
    @(negedge clk); clearInputs(); rst_n = 1'b0; #1 rst_n = 1'b1;
    resultsrcEb0 = 1'b1; rdE = 5'd7; rs1D = 5'd7;
    repeat (20) @(posedge clk);
    #1 clearInputs(); pcsrcE = 1'b1;
    repeat (3) @(posedge clk);
    #1 pcsrcE = 1'b0;
    #1;
`ifdef HAZ_PERF_CNT_EN
    chk("perf_stall_sat", int'(perf_stall), 15);
    chk("perf_flush", int'(perf_flush), 3);
`else
    chk("perf_stall_off", int'(perf_stall), 0);
    chk("perf_flush_off", int'(perf_flush), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
